// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: grants up to NPORT of NFU finished FUs per cycle,
// round-robin, onto the free writeback ports and stalls the losers.

package int_wb_arbiter_pkg;
  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [6:0]  prd;
    logic        rd_we;
    logic        exc;
    logic [31:0] data;
  } comwbInfo_t;
endpackage

module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int NFU   = 4,
  parameter int NPORT = 2,
  parameter int PTRW  = $clog2(NFU)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NFU-1:0]             i_fu_finished,
  input  comwbInfo_t                 i_comwbInfo [NFU],
  output logic [NFU-1:0]             o_fu_stall,
  input  logic [NPORT-1:0]           i_port_block,
  output logic [NPORT-1:0]           o_wb_vld,
  output comwbInfo_t                 o_wb_info [NPORT],
  output logic [$clog2(NPORT+1)-1:0] o_grant_cnt,
  output logic [31:0]                o_stall_cycles
);

  localparam int CNTW = $clog2(NPORT+1);
  localparam int PW   = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] rr_ptr_n;
  logic [PTRW-1:0] last_idx;
  logic [PTRW-1:0] scan_idx;
  logic [PTRW:0]   scan_sum;
  logic [PW-1:0]   free_idx [NPORT+1];
  logic [CNTW-1:0] free_cnt;
  logic [CNTW-1:0] n_grant;
  logic [NFU-1:0]  grant;
  logic [NPORT-1:0] route_vld;
  logic [PTRW-1:0] route_src [NPORT];

  // Compact list of unblocked ports, ascending.
  // NOTE: blocking assignments in always_comb are intentional; free_cnt is
  // read back within the same loop iteration as a running index.
  always_comb begin
    free_cnt = '0;
    for (int k = 0; k <= NPORT; k++) free_idx[k] = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (!i_port_block[p]) begin
        free_idx[free_cnt] = PW'(p);
        free_cnt           = free_cnt + CNTW'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    grant     = '0;
    route_vld = '0;
    n_grant   = '0;
    last_idx  = rr_ptr;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int p = 0; p < NPORT; p++) route_src[p] = '0;
    for (int j = 0; j < NFU; j++) begin
      scan_sum = {1'b0, rr_ptr} + (PTRW+1)'(j);
      if (scan_sum >= (PTRW+1)'(NFU)) scan_sum = scan_sum - (PTRW+1)'(NFU);
      scan_idx = scan_sum[PTRW-1:0];
      if (i_fu_finished[scan_idx] && (n_grant < free_cnt)) begin
        grant[scan_idx]                = 1'b1;
        route_vld[free_idx[n_grant]]   = 1'b1;
        route_src[free_idx[n_grant]]   = scan_idx;
        last_idx                       = scan_idx;
        n_grant                        = n_grant + CNTW'(1);
      end
    end
  end

  assign o_fu_stall = i_fu_finished & ~grant;
  assign rr_ptr_n   = (last_idx == PTRW'(NFU-1)) ? '0 : last_idx + PTRW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      o_wb_vld       <= '0;
      o_grant_cnt    <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (n_grant != '0) rr_ptr <= rr_ptr_n;
      o_wb_vld    <= route_vld;
      o_grant_cnt <= n_grant;
      if ((|o_fu_stall) && (o_stall_cycles != 32'hFFFF_FFFF))
        o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end

  // NOTE: the payload path carries no reset; o_wb_vld qualifies it.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) o_wb_info[p] <= i_comwbInfo[route_src[p]];
  end

  // Grants and used ports must pair up one-to-one.
  assert property (@(posedge clk) disable iff (rst)
    $countones(grant) == $countones(route_vld));

  for (genvar p = 0; p < NPORT; p++) begin : g_port_chk
    assert property (@(posedge clk) disable iff (rst)
      o_wb_vld[p] |-> !$past(i_port_block[p]));
    for (genvar q = p + 1; q < NPORT; q++) begin : g_pair_chk
      assert property (@(posedge clk) disable iff (rst)
        !(route_vld[p] && route_vld[q] && (route_src[p] == route_src[q])));
    end
  end

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Self-checking bench for int_wb_arbiter: hand-derived vector table, blocked
// and reset sequences, then a random run against a scoreboard model.

module tb_int_wb_arbiter;
  import int_wb_arbiter_pkg::*;

  localparam int NFU   = 4;
  localparam int NPORT = 2;
  localparam int CNTW  = $clog2(NPORT+1);

  logic                clk = 1'b0;
  logic                rst;
  logic [NFU-1:0]      i_fu_finished;
  comwbInfo_t          i_comwbInfo [NFU];
  logic [NFU-1:0]      o_fu_stall;
  logic [NPORT-1:0]    i_port_block;
  logic [NPORT-1:0]    o_wb_vld;
  comwbInfo_t          o_wb_info [NPORT];
  logic [CNTW-1:0]     o_grant_cnt;
  logic [31:0]         o_stall_cycles;

  int_wb_arbiter #(.NFU(NFU), .NPORT(NPORT)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_fu_finished  (i_fu_finished),
    .i_comwbInfo    (i_comwbInfo),
    .o_fu_stall     (o_fu_stall),
    .i_port_block   (i_port_block),
    .o_wb_vld       (o_wb_vld),
    .o_wb_info      (o_wb_info),
    .o_grant_cnt    (o_grant_cnt),
    .o_stall_cycles (o_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NPORT-1:0]             vld;
    comwbInfo_t [NPORT-1:0]       info;
    logic [CNTW-1:0]              cnt;
  } exp_t;

  typedef struct {
    logic [NFU-1:0]   req;
    logic [NPORT-1:0] blk;
    logic [NFU-1:0]   stall;
    logic [NPORT-1:0] vld;
    int               src0;
    int               src1;
    logic [CNTW-1:0]  cnt;
  } vec_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          m_ptr  = 0;
  int unsigned m_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic comwbInfo_t mk_pay(input int i);
    comwbInfo_t c;
    c.rob_idx = 6'(i + 1);
    c.prd     = 7'(i * 3 + 5);
    c.rd_we   = 1'b1;
    c.exc     = 1'b0;
    c.data    = 32'hC0DE_0000 + 32'(i);
    return c;
  endfunction

  // Reference: gather free ports, walk FUs from the pointer, pair them up.
  function automatic void model(input logic [NFU-1:0] req, input logic [NPORT-1:0] blk,
                                output logic [NFU-1:0] stall, output exp_t e, output int nptr);
    int fp [$];
    int k;
    e     = '0;
    stall = req;
    nptr  = m_ptr;
    k     = 0;
    for (int p = 0; p < NPORT; p++) if (!blk[p]) fp.push_back(p);
    for (int n = 0; n < NFU; n++) begin
      int f;
      f = (m_ptr + n) % NFU;
      if (req[f] && k < fp.size()) begin
        e.vld[fp[k]]  = 1'b1;
        e.info[fp[k]] = i_comwbInfo[f];
        stall[f]      = 1'b0;
        k++;
        nptr = (f + 1) % NFU;
      end
    end
    e.cnt = CNTW'(k);
  endfunction

  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic step(input logic [NFU-1:0] req, input logic [NPORT-1:0] blk,
                      input logic [NFU-1:0] want_stall, input exp_t want, input string name);
    logic [NFU-1:0] ms;
    exp_t           me;
    exp_t           got;
    int             nptr;
    i_fu_finished = req;
    i_port_block  = blk;
    model(req, blk, ms, me, nptr);
    #2;
    check($sformatf("%s stall", name), 64'(o_fu_stall), 64'(want_stall));
    sb.push_back(want);
    @(posedge clk);
    m_ptr = nptr;
    if ((|want_stall) && m_stall != 32'hFFFF_FFFF) m_stall++;
    #1;
    got = sb.pop_front();
    for (int p = 0; p < NPORT; p++) begin
      check($sformatf("%s p%0d vld", name, p), 64'(o_wb_vld[p]), 64'(got.vld[p]));
      if (got.vld[p]) check($sformatf("%s p%0d info", name, p), 64'(o_wb_info[p]), 64'(got.info[p]));
    end
    check($sformatf("%s grant_cnt", name), 64'(o_grant_cnt), 64'(got.cnt));
    check($sformatf("%s stall_cycles", name), 64'(o_stall_cycles), 64'(m_stall));
  endtask

  task automatic mstep(input logic [NFU-1:0] req, input logic [NPORT-1:0] blk,
                       input string name, output logic [NFU-1:0] ms);
    exp_t me;
    int   nptr;
    i_fu_finished = req;
    i_port_block  = blk;
    model(req, blk, ms, me, nptr);
    step(req, blk, ms, me, name);
  endtask

  function automatic exp_t vec_exp(input vec_t v);
    exp_t e;
    e     = '0;
    e.vld = v.vld;
    e.cnt = v.cnt;
    if (v.vld[0]) e.info[0] = i_comwbInfo[v.src0];
    if (v.vld[1]) e.info[1] = i_comwbInfo[v.src1];
    return e;
  endfunction

  task automatic do_reset(input string name);
    rst           = 1'b1;
    i_fu_finished = '0;
    i_port_block  = '0;
    @(posedge clk);
    #1;
    check($sformatf("%s wb_vld", name), 64'(o_wb_vld), 64'(0));
    check($sformatf("%s grant_cnt", name), 64'(o_grant_cnt), 64'(0));
    check($sformatf("%s stall_cycles", name), 64'(o_stall_cycles), 64'(0));
    check($sformatf("%s fu_stall", name), 64'(o_fu_stall), 64'(0));
    rst     = 1'b0;
    m_ptr   = 0;
    m_stall = 0;
    sb.delete();
  endtask

  initial begin
    vec_t           vt [9];
    vec_t           v;
    logic [NFU-1:0] ms;
    logic [NFU-1:0] pending;
    logic [NFU-1:0] req;
    logic [NFU-1:0] granted;
    logic [NPORT-1:0] blk;
    logic [63:0]    r64;
    int             waits [NFU];
    int unsigned    stall_base;

    vt[0] = '{4'b1111, 2'b00, 4'b1100, 2'b11, 0, 1, 2'd2};
    vt[1] = '{4'b1111, 2'b00, 4'b0011, 2'b11, 2, 3, 2'd2};
    vt[2] = '{4'b1111, 2'b00, 4'b1100, 2'b11, 0, 1, 2'd2};
    vt[3] = '{4'b0000, 2'b00, 4'b0000, 2'b00, 0, 0, 2'd0};
    vt[4] = '{4'b0001, 2'b00, 4'b0000, 2'b01, 0, 0, 2'd1};
    vt[5] = '{4'b1000, 2'b00, 4'b0000, 2'b01, 3, 0, 2'd1};
    vt[6] = '{4'b0101, 2'b01, 4'b0100, 2'b10, 0, 0, 2'd1};
    vt[7] = '{4'b0110, 2'b10, 4'b0100, 2'b01, 1, 0, 2'd1};
    vt[8] = '{4'b1010, 2'b00, 4'b0000, 2'b11, 3, 1, 2'd2};

    for (int i = 0; i < NFU; i++) i_comwbInfo[i] = mk_pay(i);
    rst = 1'b1;
    i_fu_finished = '0;
    i_port_block  = '0;
    @(posedge clk);
    do_reset("reset");

    for (int i = 0; i < 9; i++) begin
      v = vt[i];
      step(v.req, v.blk, v.stall, vec_exp(v), $sformatf("vec%0d", i));
    end

    // All ports blocked while FU1 waits, then released.
    stall_base = m_stall;
    for (int c = 0; c < 5; c++) begin
      v = '{4'b0010, 2'b11, 4'b0010, 2'b00, 0, 0, 2'd0};
      step(v.req, v.blk, v.stall, vec_exp(v), $sformatf("blocked%0d", c));
    end
    check("blocked stall_cycles+5", 64'(o_stall_cycles), 64'(stall_base + 5));
    v = '{4'b0010, 2'b00, 4'b0000, 2'b01, 1, 0, 2'd1};
    step(v.req, v.blk, v.stall, vec_exp(v), "unblock");

    // Random traffic; FUs hold requests and payload until granted.
    pending = '0;
    for (int i = 0; i < NFU; i++) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NFU; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          r64 = {$urandom, $urandom};
          i_comwbInfo[i] = r64[$bits(comwbInfo_t)-1:0];
        end
      end
      req = pending;
      blk = ($urandom_range(0, 3) == 0) ? NPORT'($urandom_range(0, 3)) : '0;
      mstep(req, blk, "rand", ms);
      granted = req & ~ms;
      for (int i = 0; i < NFU; i++) begin
        if (ms[i] && blk == '0) waits[i]++;
        if (granted[i]) begin
          check($sformatf("fairness fu%0d", i), 64'(waits[i] <= NFU / NPORT), 64'(1));
          waits[i]   = 0;
          pending[i] = 1'b0;
        end
      end
    end

    // Reset with both ports valid; pointer must restart at FU0.
    for (int i = 0; i < NFU; i++) i_comwbInfo[i] = mk_pay(i);
    mstep(4'b1111, 2'b00, "pre_reset", ms);
    check("pre_reset both valid", 64'(o_wb_vld), 64'(2'b11));
    do_reset("mid_reset");
    v = '{4'b1111, 2'b00, 4'b1100, 2'b11, 0, 1, 2'd2};
    step(v.req, v.blk, v.stall, vec_exp(v), "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
